// File: rtl/karatsuba_pkg.sv
// karatsuba_pkg: shared width helpers for the Karatsuba multiplier blocks.
// Split widths: N_HI = N/2 (upper half), N_LO = (N+1)/2 (lower half).
// z0 = a0*b0, z1 = (a0+a1)*(b0+b1), z2 = a1*b1; mid carries one extra sign bit.
package karatsuba_pkg;

    localparam int PIPE_DEPTH = 3;

    function automatic int n_hi(input int n);
        return n / 2;
    endfunction

    function automatic int n_lo(input int n);
        return (n + 1) / 2;
    endfunction

    function automatic int z0_w(input int n);
        return 2 * n_lo(n);
    endfunction

    function automatic int z1_w(input int n);
        return 2 * n_lo(n) + 2;
    endfunction

    function automatic int z2_w(input int n);
        return 2 * n_hi(n);
    endfunction

    function automatic int mid_w(input int n);
        return 2 * n_lo(n) + 3;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: valid/ready controller for a DEPTH-stage pipeline with bubble collapse.
// Ports: clk, rst_n (async active-low), in_valid/in_ready (upstream handshake),
//        out_ready (downstream accept), valid[i] (stage i holds data),
//        load[i] (stage i data registers capture this cycle).
module pipe_ctrl #(
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic [DEPTH-1:0] valid,
    output logic [DEPTH-1:0] load
);

    logic [DEPTH-1:0] v_q, v_d, adv;
    logic [DEPTH:0]   up;

    always_comb begin
        up   = {v_q, in_valid};
        adv  = '0;
        load = '0;
        v_d  = v_q;
        for (int i = 0; i < DEPTH; i++) begin
            // stage i is blocked only when it and every stage after it are full and the sink stalls
            adv[i]  = out_ready | ~&(v_q | DEPTH'((1 << i) - 1));
            load[i] = adv[i] & up[i];
            v_d[i]  = adv[i] ? up[i] : v_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready = adv[0];
    assign valid    = v_q;

endmodule

// File: rtl/karatsuba_combine.sv
// karatsuba_combine: 3-stage recombination of Karatsuba partial products into a*b.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with z0, z1, z2 partial
//        products; out_valid/out_ready with c (2*N_BITS result) and err (set when
//        z1 < z0 + z2, in which case c is forced to 0).
module karatsuba_combine
    import karatsuba_pkg::*;
#(
    parameter int N_BITS = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [z0_w(N_BITS)-1:0]   z0,
    input  logic [z1_w(N_BITS)-1:0]   z1,
    input  logic [z2_w(N_BITS)-1:0]   z2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*N_BITS-1:0]       c,
    output logic                      err
);

    localparam int N_LO = n_lo(N_BITS);
    localparam int Z0W  = z0_w(N_BITS);
    localparam int Z2W  = z2_w(N_BITS);
    localparam int MW   = mid_w(N_BITS);
    localparam int CW   = 2 * N_BITS;

    logic [PIPE_DEPTH-1:0] vld, ld;
    logic [MW-1:0]         m1_q, m1_d, mid_q, mid_d;
    logic [Z0W-1:0]        z0_1_q, z0_1_d, z0_2_q, z0_2_d;
    logic [Z2W-1:0]        z2_1_q, z2_1_d, z2_2_q, z2_2_d;
    logic [CW-1:0]         c_q, c_d;
    logic                  err_q, err_d;
    logic                  unused_ok;

    pipe_ctrl #(.DEPTH(PIPE_DEPTH)) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .valid     (vld),
        .load      (ld)
    );

    always_comb begin
        m1_d   = ld[0] ? MW'(z1) - MW'(z0) : m1_q;
        z0_1_d = ld[0] ? z0 : z0_1_q;
        z2_1_d = ld[0] ? z2 : z2_1_q;
        mid_d  = ld[1] ? m1_q - MW'(z2_1_q) : mid_q;
        z0_2_d = ld[1] ? z0_1_q : z0_2_q;
        z2_2_d = ld[1] ? z2_1_q : z2_2_q;
        // a negative middle term means the triple cannot come from one multiplication
        err_d  = ld[2] ? mid_q[MW-1] : err_q;
        // z0 fills exactly 2*N_LO bits, so {z2, z0} is the exact z2<<2*N_LO + z0
        c_d    = ld[2] ? (mid_q[MW-1] ? '0 : {z2_2_q, z0_2_q} + (CW'(mid_q[2*N_LO:0]) << N_LO)) : c_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q   <= '0;
            z0_1_q <= '0;
            z2_1_q <= '0;
            mid_q  <= '0;
            z0_2_q <= '0;
            z2_2_q <= '0;
            c_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            m1_q   <= m1_d;
            z0_1_q <= z0_1_d;
            z2_1_q <= z2_1_d;
            mid_q  <= mid_d;
            z0_2_q <= z0_2_d;
            z2_2_q <= z2_2_d;
            c_q    <= c_d;
            err_q  <= err_d;
        end
    end

    // only the last valid bit is an output; bit 2*N_LO+1 of mid is always 0 for a non-negative result
    assign unused_ok = ^{vld[PIPE_DEPTH-2:0], mid_q[MW-2]};

    assign out_valid = vld[PIPE_DEPTH-1];
    assign c         = c_q;
    assign err       = err_q;

endmodule

// File: tb/tb_karatsuba_combine.sv
// tb_karatsuba_combine: scoreboard bench for karatsuba_combine at N_BITS = 15 and 16.
module tb_karatsuba_combine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready;
    logic        ir15, ir16, ov15, ov16, err15, err16;
    logic [15:0] z0a;
    logic [17:0] z1a;
    logic [13:0] z2a;
    logic [29:0] c15;
    logic [15:0] z0b;
    logic [17:0] z1b;
    logic [15:0] z2b;
    logic [31:0] c16;
    logic [30:0] exp15, m15;
    logic [32:0] exp16, m16;
    logic [30:0] q15[$];
    logic [32:0] q16[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    karatsuba_combine #(.N_BITS(15)) dut15 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir15),
        .z0(z0a), .z1(z1a), .z2(z2a), .out_valid(ov15), .out_ready(out_ready),
        .c(c15), .err(err15)
    );

    karatsuba_combine #(.N_BITS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
        .z0(z0b), .z1(z1b), .z2(z2b), .out_valid(ov16), .out_ready(out_ready),
        .c(c16), .err(err16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set16(input int a, input int b);
        z0b   = 16'((a & 255) * (b & 255));
        z1b   = 18'(((a & 255) + (a >> 8)) * ((b & 255) + (b >> 8)));
        z2b   = 16'((a >> 8) * (b >> 8));
        exp16 = {1'b0, 32'(longint'(a) * longint'(b))};
    endtask

    task automatic set15_raw(input int z0, input int z1, input int z2, input longint cv, input bit e);
        z0a   = 16'(z0);
        z1a   = 18'(z1);
        z2a   = 14'(z2);
        exp15 = {e, 30'(cv)};
        set16(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    endtask

    task automatic set15(input int a, input int b);
        set15_raw((a & 255) * (b & 255), ((a & 255) + (a >> 8)) * ((b & 255) + (b >> 8)),
                  (a >> 8) * (b >> 8), longint'(a) * longint'(b), 1'b0);
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = in_valid && ir15;
        if (acc) q15.push_back(exp15);
        if (in_valid && ir16) q16.push_back(exp16);
        @(posedge clk);
        #1;
    endtask

    task automatic send();
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) tick(acc);
        chk("accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic lat_check();
        chk("lat_k1", 64'(ov15), 64'd0);
        @(posedge clk); #1;
        chk("lat_k2", 64'(ov15), 64'd0);
        @(posedge clk); #1;
        chk("lat_k3", 64'(ov15), 64'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 100 && (q15.size() != 0 || q16.size() != 0); i++) begin
            @(posedge clk); #1;
        end
        chk("drain15", 64'(q15.size()), 64'd0);
        chk("drain16", 64'(q16.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_ready && ov15) begin
            if (q15.size() == 0) chk("spurious15", 64'd1, 64'd0);
            else begin
                m15 = q15.pop_front();
                chk("c15", 64'(c15), 64'(m15[29:0]));
                chk("err15", 64'(err15), 64'(m15[30]));
            end
        end
        if (rst_n && out_ready && ov16) begin
            if (q16.size() == 0) chk("spurious16", 64'd1, 64'd0);
            else begin
                m16 = q16.pop_front();
                chk("c16", 64'(c16), 64'(m16[31:0]));
                chk("err16", 64'(err16), 64'(m16[32]));
            end
        end
    end

    initial begin
        bit          acc;
        int          sent, acc_n, stale;
        logic [29:0] hold_c;
        logic        hold_e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set15_raw(0, 0, 0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov", 64'(ov15), 64'd0);
        chk("rst_c", 64'(c15), 64'd0);
        chk("rst_err", 64'(err15), 64'd0);
        chk("rst_in_ready", 64'(ir15), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        set15_raw(7581, 16695, 1248, 83810205, 1'b0);
        send();
        lat_check();
        drain();
        set15_raw(65025, 145924, 16129, 1073676289, 1'b0);
        send();
        set15_raw(0, 0, 0, 0, 1'b0);
        send();
        set15_raw(100, 50, 0, 0, 1'b1);
        send();
        set15(1000, 2000);
        send();
        drain();
        sent = 0;
        for (int t = 0; t < 12; t++) begin
            out_ready = (t >= 5);
            if (sent < 6 && !in_valid) begin
                set15(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)));
                in_valid = 1'b1;
            end
            #1;
            if (t == 3 || t == 4) chk("bp_in_ready_low", 64'(ir15), 64'd0);
            if (t == 3) begin
                hold_c = c15;
                hold_e = err15;
                chk("bp_ov", 64'(ov15), 64'd1);
            end
            if (t == 4) begin
                chk("bp_hold_ov", 64'(ov15), 64'd1);
                chk("bp_hold_c", 64'(c15), 64'(hold_c));
                chk("bp_hold_err", 64'(err15), 64'(hold_e));
            end
            if (t == 5) chk("bp_in_ready_high", 64'(ir15), 64'd1);
            tick(acc);
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("bp_sent", 64'(sent), 64'd6);
        drain();
        acc_n = 0;
        for (int cyc = 0; cyc < 60000 && acc_n < 10000; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                set15(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)));
                in_valid = 1'b1;
            end
            tick(acc);
            if (acc) begin
                acc_n++;
                in_valid = 1'b0;
            end
        end
        chk("rand_count", 64'(acc_n), 64'd10000);
        drain();
        out_ready = 1'b0;
        repeat (3) begin
            set15(int'($urandom_range(0, 32767)), int'($urandom_range(0, 32767)));
            send();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 64'(ov15), 64'd0);
        chk("midrst_in_ready", 64'(ir15), 64'd1);
        q15.delete();
        q16.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        stale     = 0;
        repeat (6) begin
            @(negedge clk);
            if (ov15 || ov16) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        @(posedge clk); #1;
        set15(12345, 6789);
        send();
        lat_check();
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
